// File: rtl/alarm_button_pio.sv
// alarm_button_pio: debounced button PIO with edge capture and a masked level IRQ on an Avalon-MM slave.
// Latency: a held pin change reaches stable 2+DEBOUNCE_CYCLES edges after it is first sampled; readdata follows address by 1 cycle.
// Backpressure: none; the slave is always ready and writes take effect on the edge they are presented.
//
// Ports:
//   clk         single clock, all state on the rising edge
//   reset       synchronous active-high reset
//   address     word address: 0 stable, 1 irqmask, 2 reads zero, 3 edgecapture (write-1-to-clear)
//   chipselect  qualifies write
//   write       write strobe
//   writedata   write data; only bits [WIDTH-1:0] are used
//   in_port     raw asynchronous button levels
//   readdata    registered read data, zero-extended
//   irq         level interrupt, |(edgecapture & irqmask)
module alarm_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 1,
  parameter int INIT_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] INIT_VEC = (INIT_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  // Two-flop synchronizer per bit
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  // Debounce state
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            stable_q;
  logic [WIDTH-1:0]            stable_d;
  logic [WIDTH-1:0]            stable_prev_q;

  // Register file
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_next;

  logic wr_en;
  logic mask_wr;
  logic clr_wr;

  // Upper writedata bits carry no meaning for this block; fold them into a
  // dedicated sink so they are visibly consumed.
  logic wdata_unused;
  assign wdata_unused = ^writedata;

  // A bit only counts while the synchronized level disagrees with the
  // accepted level. Any agreeing sample restarts the run, so a glitch must
  // persist for DEBOUNCE_CYCLES consecutive synchronized samples to land.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q2[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_q2[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edges come from the debounced level against its one-cycle-old copy.
  // Reset loads both with the same idle level, so reset never fabricates an edge.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_bits = stable_q & ~stable_prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_bits = ~stable_q & stable_prev_q;
    end else begin : g_both
      assign edge_bits = stable_q ^ stable_prev_q;
    end
  endgenerate

  assign wr_en    = chipselect & write;
  assign mask_wr  = wr_en && (address == 2'd1);
  assign clr_wr   = wr_en && (address == 2'd3);
  assign clr_bits = clr_wr ? writedata[WIDTH-1:0] : '0;

  // Read mux is evaluated every cycle regardless of chipselect.
  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = stable_q;
      2'd1:    rd_next[WIDTH-1:0] = irqmask_q;
      2'd3:    rd_next[WIDTH-1:0] = edgecap_q;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1       <= INIT_VEC;
      sync_q2       <= INIT_VEC;
      cnt_q         <= '0;
      stable_q      <= INIT_VEC;
      stable_prev_q <= INIT_VEC;
      irqmask_q     <= '0;
      edgecap_q     <= '0;
      readdata      <= '0;
    end else begin
      sync_q1       <= in_port;
      sync_q2       <= sync_q1;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      if (mask_wr) begin
        irqmask_q <= writedata[WIDTH-1:0];
      end
      // Clear first, then OR in new edges: a capture in the same cycle as a
      // clear of that bit survives.
      edgecap_q     <= (edgecap_q & ~clr_bits) | edge_bits;
      readdata      <= rd_next;
    end
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_alarm_button_pio.sv
`timescale 1ns/1ps
module tb_alarm_button_pio;

  localparam int D = 16;

  logic        clk;
  logic        reset;
  logic [1:0]  addr_a, addr_b;
  logic        cs_a, cs_b, wr_a, wr_b;
  logic [31:0] wd_a, wd_b;
  logic [3:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  alarm_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .INIT_LEVEL(1)) dut_a (
    .clk(clk), .reset(reset), .address(addr_a), .chipselect(cs_a), .write(wr_a),
    .writedata(wd_a), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
  );

  alarm_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .INIT_LEVEL(1)) dut_b (
    .clk(clk), .reset(reset), .address(addr_b), .chipselect(cs_b), .write(wr_b),
    .writedata(wd_b), .in_port(in_b), .readdata(rd_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pin history pipeline plus a window of the last D
  // synchronized samples; a bit is accepted once the whole window disagrees
  // with the accepted level.
  logic [31:0] m_s1[2], m_s2[2], m_stable[2], m_prev[2], m_mask[2], m_cap[2], m_rd[2];
  logic [31:0] m_hist[2][D];

  function automatic int width_of(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int etype_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic model_step(input int k, input logic rst, input logic [1:0] a, input logic cs,
                            input logic wr, input logic [31:0] wd, input logic [31:0] inp);
    logic [31:0] wmask, sync, nstable, edges, ncap, nrd;
    bit all_diff;
    wmask = (32'd1 << width_of(k)) - 32'd1;
    if (rst) begin
      m_s1[k] = wmask; m_s2[k] = wmask; m_stable[k] = wmask; m_prev[k] = wmask;
      m_mask[k] = '0; m_cap[k] = '0; m_rd[k] = '0;
      for (int i = 0; i < D; i++) m_hist[k][i] = wmask;
      return;
    end
    sync = m_s2[k];
    for (int i = D - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
    m_hist[k][0] = sync;
    nstable = m_stable[k];
    for (int b = 0; b < width_of(k); b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < D; i++)
        if (m_hist[k][i][b] == m_stable[k][b]) all_diff = 1'b0;
      if (all_diff) nstable[b] = sync[b];
    end
    case (etype_of(k))
      0:       edges = m_stable[k] & ~m_prev[k];
      1:       edges = ~m_stable[k] & m_prev[k];
      default: edges = m_stable[k] ^ m_prev[k];
    endcase
    edges = edges & wmask;
    ncap = m_cap[k];
    if (cs && wr && a == 2'd3) ncap = ncap & ~wd;
    ncap = (ncap | edges) & wmask;
    case (a)
      2'd0:    nrd = m_stable[k];
      2'd1:    nrd = m_mask[k];
      2'd3:    nrd = m_cap[k];
      default: nrd = '0;
    endcase
    if (cs && wr && a == 2'd1) m_mask[k] = wd & wmask;
    m_rd[k]     = nrd;
    m_cap[k]    = ncap;
    m_prev[k]   = m_stable[k];
    m_stable[k] = nstable;
    m_s2[k]     = m_s1[k];
    m_s1[k]     = inp & wmask;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, reset, addr_a, cs_a, wr_a, wd_a, {28'd0, in_a});
    model_step(1, reset, addr_b, cs_b, wr_b, wd_b, {24'd0, in_b});
    @(negedge clk);
    chk("model_rd_a",  rd_a, m_rd[0]);
    chk("model_irq_a", {31'd0, irq_a}, {31'd0, |(m_cap[0] & m_mask[0])});
    chk("model_rd_b",  rd_b, m_rd[1]);
    chk("model_irq_b", {31'd0, irq_b}, {31'd0, |(m_cap[1] & m_mask[1])});
  endtask

  task automatic bus_wr(input int k, input logic [1:0] a, input logic [31:0] d);
    if (k == 0) begin cs_a = 1'b1; wr_a = 1'b1; addr_a = a; wd_a = d; end
    else        begin cs_b = 1'b1; wr_b = 1'b1; addr_b = a; wd_b = d; end
    tick();
    if (k == 0) begin cs_a = 1'b0; wr_a = 1'b0; end
    else        begin cs_b = 1'b0; wr_b = 1'b0; end
  endtask

  // Ticks until readdata bit b of instance k reads val; 0 means never seen.
  task automatic wait_bit(input int k, input int b, input logic val, output int n);
    logic [31:0] cur;
    n = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      cur = (k == 0) ? rd_a : rd_b;
      if (cur[b] === val) begin
        n = t;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    reset = 1'b1;
    addr_a = 2'd0; addr_b = 2'd0; cs_a = 1'b0; cs_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    wd_a = '0; wd_b = '0; in_a = 4'hF; in_b = 8'hFF;

    // Reset state
    repeat (3) tick();
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_irq_a", {31'd0, irq_a}, 32'h0);
    reset = 1'b0;

    // Idle read of stable, first read one cycle after release
    tick();
    chk("idle_stable", rd_a, 32'h0000_000F);
    chk("idle_irq", {31'd0, irq_a}, 32'h0);

    // Falling edge on bit 0: stable falls 18 edges after the change,
    // visible on readdata one edge later together with irq
    bus_wr(0, 2'd1, 32'h1);
    addr_a = 2'd0;
    in_a = 4'hE;
    wait_bit(0, 0, 1'b0, n);
    chk("fall_latency", 32'(n), 32'd19);
    chk("fall_irq", {31'd0, irq_a}, 32'h1);
    addr_a = 2'd3;
    tick();
    chk("fall_cap", rd_a, 32'h1);

    // Short glitch on bit 2 is rejected
    in_a = 4'hF;
    bus_wr(0, 2'd3, 32'hF);
    repeat (25) tick();
    in_a = 4'hB;
    repeat (10) tick();
    in_a = 4'hF;
    repeat (30) tick();
    chk("glitch_cap", rd_a, 32'h0);
    chk("glitch_irq", {31'd0, irq_a}, 32'h0);
    addr_a = 2'd0;
    tick();
    chk("glitch_stable", rd_a, 32'h0000_000F);

    // Write-1-to-clear and masking
    in_a = 4'hC;
    repeat (25) tick();
    addr_a = 2'd3;
    tick();
    chk("cap3", rd_a, 32'h3);
    bus_wr(0, 2'd3, 32'h1);
    chk("clr_irq_drop", {31'd0, irq_a}, 32'h0);
    addr_a = 2'd3;
    tick();
    chk("clr_cap", rd_a, 32'h2);
    bus_wr(0, 2'd1, 32'hFFFF_FFF2);
    chk("mask_irq", {31'd0, irq_a}, 32'h1);
    addr_a = 2'd1;
    tick();
    chk("mask_read", rd_a, 32'h2);

    // Clear collides with a new falling edge on bit 1: set wins
    in_a = 4'hE;
    repeat (25) tick();
    in_a = 4'hC;
    repeat (18) tick();
    bus_wr(0, 2'd3, 32'h2);
    chk("collide_irq", {31'd0, irq_a}, 32'h1);
    tick();
    chk("collide_cap", rd_a, 32'h2);

    // Reset during a debounce at count 10
    bus_wr(0, 2'd3, 32'hF);
    in_a = 4'hF;
    repeat (25) tick();
    in_a = 4'h7;
    repeat (12) tick();
    reset = 1'b1;
    in_a = 4'hF;
    tick();
    chk("midrst_rd", rd_a, 32'h0);
    chk("midrst_irq", {31'd0, irq_a}, 32'h0);
    reset = 1'b0;
    addr_a = 2'd3;
    repeat (25) tick();
    chk("midrst_cap", rd_a, 32'h0);
    addr_a = 2'd1;
    tick();
    chk("midrst_mask", rd_a, 32'h0);
    addr_a = 2'd0;
    tick();
    chk("midrst_stable", rd_a, 32'h0000_000F);

    // Eight-bit both-edge instance, bit 7
    bus_wr(1, 2'd1, 32'h80);
    addr_b = 2'd0;
    in_b = 8'h7F;
    wait_bit(1, 7, 1'b0, n);
    chk("b_fall_latency", 32'(n), 32'd19);
    chk("b_fall_irq", {31'd0, irq_b}, 32'h1);
    addr_b = 2'd3;
    tick();
    chk("b_fall_cap", rd_b, 32'h80);
    bus_wr(1, 2'd3, 32'h80);
    chk("b_clr_irq", {31'd0, irq_b}, 32'h0);
    addr_b = 2'd0;
    in_b = 8'hFF;
    wait_bit(1, 7, 1'b1, n);
    chk("b_rise_latency", 32'(n), 32'd19);
    chk("b_rise_irq", {31'd0, irq_b}, 32'h1);
    addr_b = 2'd3;
    tick();
    chk("b_rise_cap", rd_b, 32'h80);

    // Randomized traffic against the model
    for (int seg = 0; seg < 40; seg++) begin
      in_a = 4'($urandom);
      in_b = 8'($urandom);
      len = $urandom_range(1, 40);
      for (int t = 0; t < len; t++) begin
        addr_a = 2'($urandom); addr_b = 2'($urandom);
        cs_a = ($urandom_range(0, 3) == 0); wr_a = ($urandom_range(0, 1) == 0);
        cs_b = ($urandom_range(0, 3) == 0); wr_b = ($urandom_range(0, 1) == 0);
        wd_a = $urandom; wd_b = $urandom;
        reset = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    reset = 1'b0; cs_a = 1'b0; cs_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_button_pio.md
ALARM_BUTTON_PIO -- requirements
Module: alarm_button_pio

Interface
REQ-001 Parameter WIDTH, default 4, number of button inputs (legal 1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a new level (legal 2..65535).
REQ-003 Parameter EDGE_TYPE, default 1, edge captured: 0 rising, 1 falling, 2 both.
REQ-004 Parameter INIT_LEVEL, default 1, reset value of every synchronizer and debounced bit (idle level of the buttons).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select; qualifies write.
REQ-009 write  input  1  write strobe, valid only with chipselect=1.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  raw asynchronous button levels.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer per bit; sync output = in_port delayed 2 cycles.
REQ-015 Each bit SHALL own a counter of ceil(log2(DEBOUNCE_CYCLES)) bits and a debounced register "stable".
REQ-016 When sync bit equals stable, its counter SHALL clear to 0.
REQ-017 When sync bit differs from stable, its counter SHALL increment; on the cycle the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, stable SHALL take the sync value and the counter SHALL clear.
REQ-018 A pin change held steady SHALL appear in stable exactly 2+DEBOUNCE_CYCLES cycles after it is sampled; any glitch shorter than DEBOUNCE_CYCLES sync cycles SHALL not change stable.
REQ-019 A registered copy stable_d SHALL be kept; edge bit = stable&~stable_d (EDGE_TYPE 0), ~stable&stable_d (1), stable^stable_d (2).
REQ-020 Register map (read): addr 0 -> stable, addr 1 -> irqmask, addr 2 -> 0, addr 3 -> edgecapture; all zero-extended to 32 bits.
REQ-021 readdata SHALL be registered every cycle from address (read latency 1), independent of chipselect.
REQ-022 Write addr 1 SHALL load irqmask from writedata[WIDTH-1:0]; writes to addr 0 and 2 SHALL be ignored.
REQ-023 Write addr 3 SHALL clear each edgecapture bit whose writedata bit is 1 (write-1-to-clear).
REQ-024 An edge bit SHALL set its edgecapture bit; if set and clear occur in the same cycle, set SHALL win.
REQ-025 irq SHALL equal |(edgecapture & irqmask), combinational from registers, so it asserts the cycle after the capturing edge and deasserts the cycle after clearing or masking.
REQ-026 writedata bits above WIDTH-1 SHALL be ignored.

Reset
REQ-027 While reset=1 at a clock edge: synchronizers, stable, stable_d = {WIDTH{INIT_LEVEL}}; counters, irqmask, edgecapture, readdata = 0; hence irq = 0 the cycle after.
REQ-028 Reset asserted mid-debounce SHALL abandon the count; no edge SHALL be generated by reset itself.
REQ-029 After reset release, first valid readdata SHALL appear one cycle after address is presented.

Verification
REQ-030 Defaults; reset; in_port 4'hF idle; read addr 0 -> readdata 32'h0000000F, irq=0.
REQ-031 in_port[0] 1->0 held; stable[0] falls exactly 18 cycles later, edgecapture reads 32'h1; with irqmask=1, irq rises next cycle.
REQ-032 in_port[2] low pulse of 10 cycles (DEBOUNCE_CYCLES=16) -> stable stays 4'hF, edgecapture stays 0, irq stays 0.
REQ-033 edgecapture=4'h3, irqmask=4'h1; write 4'h1 to addr 3 -> edgecapture 4'h2, irq drops next cycle; write irqmask 4'h2 -> irq=1.
REQ-034 Write 1 to addr 3 bit 1 in the same cycle a new falling edge on bit 1 is detected -> edgecapture[1] remains 1.
REQ-035 Reset asserted at counter value 10 during a debounce -> all state at REQ-027 values, no edge; WIDTH=8, EDGE_TYPE=2 run repeats REQ-031 on bit 7 for both edges.
